encode_pack: RTL and testbench

Output bit packer for the LZS encode path, the transmit-side counterpart of the decode bit-stream interface. It accepts variable-width LZS codes (literals, offsets, lengths and end markers) from the encoder core. It concatenates them MSB-first into a contiguous bit stream and emits that stream as bytes toward the output FIFO. At end of stream it zero-pads the final partial byte and signals completion.

---
 rtl/encode_pack.sv | 129 ++++++++++++
 tb/tb_encode_pack.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/encode_pack.sv
// encode_pack: output bit packer for the LZS encode path.
//
// Concatenates variable-width codes MSB-first into a bit stream and emits
// the stream as bytes toward the output FIFO. On end of stream it zero-pads
// the final partial byte, then pulses all_end once and parks until reset.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   ce_encode  block enable; low freezes all state
//   in_valid   code present on in_data/in_width
//   in_data    right-justified code; bits at/above in_width ignored
//   in_width   code length 0..IN_WIDTH
//   in_end     last-code/flush request, qualified like in_ack
//   in_ack     combinational; code taken at this edge
//   fo_full    output FIFO full; blocks byte emission
//   out_data   packed byte (registered)
//   out_valid  one-cycle strobe per byte (registered)
//   all_end    one-cycle pulse after the final byte (registered)
module encode_pack #(
    parameter int IN_WIDTH       = 13,
    parameter int NEED_STR_WIDTH = 4,
    parameter int OUT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce_encode,
    input  logic                      in_valid,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic [NEED_STR_WIDTH-1:0] in_width,
    input  logic                      in_end,
    output logic                      in_ack,
    input  logic                      fo_full,
    output logic [OUT_WIDTH-1:0]      out_data,
    output logic                      out_valid,
    output logic                      all_end
);

    // Buffer holds up to 7 leftover bits plus one full-width code.
    localparam int BUF_W = 24;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;

    logic                w_take;
    logic                w_emit;
    logic [IN_WIDTH-1:0] w_mask;
    logic [BUF_W-1:0]    w_code_ext;
    logic [CNT_W-1:0]    w_shamt;
    logic [BUF_W-1:0]    w_place;

    // Inputs are only looked at while fewer than one byte is buffered, so a
    // take and an emit can never happen in the same cycle.
    assign w_take = ce_encode & ~rst & (r_state == S_RUN) & (r_cnt < CNT_W'(8));
    assign in_ack = w_take & in_valid;

    assign w_emit = ce_encode & (r_cnt >= CNT_W'(8)) & ~fo_full & (r_state != S_DONE);

    // Mask off stray bits above the code width, then left-align the code
    // directly below the bits already held. With cnt<8 and width<=13 the
    // shift amount never goes negative.
    assign w_mask     = ~({IN_WIDTH{1'b1}} << in_width);
    assign w_code_ext = {{(BUF_W-IN_WIDTH){1'b0}}, in_data & w_mask};
    assign w_shamt    = CNT_W'(BUF_W) - r_cnt - CNT_W'(in_width);
    assign w_place    = w_code_ext << w_shamt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf     <= '0;
            r_cnt     <= '0;
            r_state   <= S_RUN;
            out_data  <= '0;
            out_valid <= 1'b0;
            all_end   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            all_end   <= 1'b0;
            if (ce_encode) begin
                case (r_state)
                    S_RUN: begin
                        if (w_emit) begin
                            out_data  <= r_buf[BUF_W-1 -: OUT_WIDTH];
                            out_valid <= 1'b1;
                            r_buf     <= r_buf << OUT_WIDTH;
                            r_cnt     <= r_cnt - CNT_W'(OUT_WIDTH);
                        end else if (w_take) begin
                            if (in_valid) begin
                                r_buf <= r_buf | w_place;
                                r_cnt <= r_cnt + CNT_W'(in_width);
                            end
                            if (in_end)
                                r_state <= S_FLUSH;
                        end
                    end
                    S_FLUSH: begin
                        if (w_emit) begin
                            out_data  <= r_buf[BUF_W-1 -: OUT_WIDTH];
                            out_valid <= 1'b1;
                            r_buf     <= r_buf << OUT_WIDTH;
                            r_cnt     <= r_cnt - CNT_W'(OUT_WIDTH);
                        end else if (r_cnt != '0) begin
                            // Partial byte: bits below the residue are already
                            // zero, so the top byte is the padded output.
                            if (!fo_full) begin
                                out_data  <= r_buf[BUF_W-1 -: OUT_WIDTH];
                                out_valid <= 1'b1;
                                r_buf     <= '0;
                                r_cnt     <= '0;
                            end
                        end else begin
                            all_end <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_encode_pack.sv
// Scoreboard bench for encode_pack: a bit-queue model turns every accepted
// code into expected bytes; the monitor pops and compares each strobed byte.
module tb_encode_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_encode = 1'b1;
    logic        in_valid = 1'b0;
    logic [12:0] in_data = '0;
    logic [3:0]  in_width = '0;
    logic        in_end = 1'b0;
    logic        in_ack;
    logic        fo_full = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        all_end;

    encode_pack #(.IN_WIDTH(13), .NEED_STR_WIDTH(4), .OUT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .ce_encode(ce_encode), .in_valid(in_valid),
        .in_data(in_data), .in_width(in_width), .in_end(in_end), .in_ack(in_ack),
        .fo_full(fo_full), .out_data(out_data), .out_valid(out_valid),
        .all_end(all_end)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    bit         bq[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_list[$];
    int         exp_end = 0;
    int         end_cnt = 0;
    logic       prev_ae = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Reference: append code bits, cut whole bytes, pad on end.
    task automatic model_push(input logic [12:0] d, input int w, input bit e);
        logic [7:0] b;
        for (int i = w - 1; i >= 0; i--) bq.push_back(d[i]);
        while (bq.size() >= 8) begin
            for (int k = 0; k < 8; k++) b[7-k] = bq.pop_front();
            exp_q.push_back(b);
        end
        if (e) begin
            if (bq.size() > 0) begin
                b = '0;
                for (int k = 0; bq.size() > 0; k++) b[7-k] = bq.pop_front();
                exp_q.push_back(b);
            end
            exp_end++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                got_q.push_back(out_data);
                if (exp_q.size() == 0) chk("byte_unexpected", {24'h0, out_data}, 32'hFFFF_FFFF);
                else chk("byte_stream", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
            if (all_end) begin
                end_cnt++;
                chk("all_end_expected", (exp_end > 0), 1);
                chk("all_end_after_bytes", exp_q.size(), 0);
                chk("all_end_width", prev_ae, 0);
                chk("ov_ae_exclusive", out_valid, 0);
                if (exp_end > 0) exp_end--;
            end
        end
        prev_ae = all_end;
    end

    task automatic do_reset();
        rst = 1'b1; ce_encode = 1'b1; fo_full = 1'b0;
        in_valid = 1'b0; in_end = 1'b0;
        bq.delete(); exp_q.delete(); got_q.delete();
        exp_end = 0; end_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one code and hold it until taken (bounded).
    task automatic send(input logic [12:0] d, input int w, input bit e);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_width = 4'(w); in_end = e;
        #1;
        while (!in_ack && n < 200) begin
            @(negedge clk); #1; n++;
        end
        chk("ack_timeout", in_ack, 1);
        if (in_ack) model_push(d, w, e);
        @(negedge clk);
        in_valid = 1'b0; in_end = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (end_cnt == 0 && n < 100) begin
            @(negedge clk); n++;
        end
        repeat (4) @(negedge clk);
        chk("all_end_count", end_cnt, 1);
    endtask

    task automatic check_got();
        chk("byte_count", got_q.size(), exp_list.size());
        for (int i = 0; i < got_q.size() && i < exp_list.size(); i++)
            chk("byte_value", {24'h0, got_q[i]}, {24'h0, exp_list[i]});
        chk("model_drained", exp_q.size(), 0);
    endtask

    initial begin
        // Reset behaviour with in_valid asserted.
        in_valid = 1'b1; in_data = 13'h1FF; in_width = 4'd9;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ack", in_ack, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", {24'h0, out_data}, 0);
            chk("rst_all_end", all_end, 0);
        end

        // Literal plus end, then DONE ignores input.
        do_reset();
        send(13'h041, 9, 1'b0);
        send(13'h180, 9, 1'b1);
        wait_end();
        in_valid = 1'b1; in_data = 13'h1FF; in_width = 4'd9;
        repeat (5) begin
            #1 chk("done_in_ack", in_ack, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        exp_list = '{8'h20, 8'hE0, 8'h00};
        check_got();
        chk("done_no_extra_end", end_cnt, 1);

        // Byte-aligned end: no pad byte.
        do_reset();
        for (int i = 0; i < 8; i++) send(13'h001, 1, (i == 7));
        wait_end();
        exp_list = '{8'hFF};
        check_got();

        // Backpressure.
        do_reset();
        fo_full = 1'b1;
        send(13'h1FFF, 13, 1'b0);
        in_valid = 1'b1; in_data = 13'h0; in_width = 4'd3; in_end = 1'b1;
        repeat (4) begin
            #1 chk("bp_in_ack", in_ack, 0);
            chk("bp_out_valid", out_valid, 0);
            @(negedge clk);
        end
        in_valid = 1'b0; in_end = 1'b0;
        fo_full = 1'b0;
        send(13'h0, 3, 1'b1);
        wait_end();
        exp_list = '{8'hFF, 8'hF8};
        check_got();

        // Enable freeze with a full byte pending.
        do_reset();
        send(13'h1ABC, 13, 1'b0);
        ce_encode = 1'b0;
        repeat (4) begin
            #1 chk("frz_out_valid", out_valid, 0);
            chk("frz_all_end", all_end, 0);
            @(negedge clk);
        end
        ce_encode = 1'b1;
        send(13'h0F5, 9, 1'b0);
        send(13'h003, 2, 1'b1);
        wait_end();
        exp_list = '{8'hD5, 8'hE3, 8'hD7};
        check_got();

        // Reset during FLUSH with 5 residual bits.
        do_reset();
        fo_full = 1'b1;
        send(13'h015, 5, 1'b1);
        repeat (2) begin
            #1 chk("mf_held_out_valid", out_valid, 0);
            @(negedge clk);
        end
        rst = 1'b1;
        bq.delete(); exp_q.delete(); exp_end = 0;
        fo_full = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mf_rst_out_valid", out_valid, 0);
            chk("mf_rst_all_end", all_end, 0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mf_post_out_valid", out_valid, 0);
            chk("mf_post_all_end", all_end, 0);
        end
        got_q.delete(); end_cnt = 0;
        send(13'h1EAA, 8, 1'b1);
        wait_end();
        exp_list = '{8'hAA};
        check_got();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
